// File: rtl/mem_burst_pkg.sv
// Shared constants and state encoding for the burst RAM tester.
package mem_burst_pkg;

    localparam logic [1:0] RAM_WIDTH8  = 2'd0;
    localparam logic [1:0] RAM_WIDTH16 = 2'd1;
    localparam logic [1:0] RAM_WIDTH32 = 2'd2;
    localparam logic [1:0] RAM_WIDTH64 = 2'd3;

    localparam int unsigned WORD_BYTES = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_WWAIT = 3'd2,
        ST_READ  = 3'd3,
        ST_RWAIT = 3'd4,
        ST_DONE  = 3'd5
    } burst_state_e;

endpackage

// File: rtl/mem_burst_buf.sv
// DEPTH x DATA_W word store: one synchronous write port, one asynchronous read port.
module mem_burst_buf #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8
) (
    input  logic                     clk_cpu,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge clk_cpu) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/mem_burst_tester.sv
// Buffers CPU words, bursts them to mem_example, optionally reads back and compares.
// Optional watchdog on WWAIT/RWAIT is enabled by defining MEM_TIMEOUT_EN.
module mem_burst_tester
    import mem_burst_pkg::*;
#(
    parameter int DATA_W         = 64,
    parameter int ADDR_W         = 28,
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     clk_cpu,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    input  logic                     flush,
    input  logic                     readback_en,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic                     mem_ready,
    input  logic                     mem_transaction_complete,
    input  logic [DATA_W-1:0]        mem_d_from_ram,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_d_to_ram,
    output logic [1:0]               mem_transaction_width,
    output logic                     mem_wstrobe,
    output logic                     mem_rstrobe,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   err_count,
    output logic [$clog2(DEPTH)-1:0] first_err_idx,
    output logic                     timeout,
    output logic [15:0]              led
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    burst_state_e      state_r;
    logic [CW-1:0]     count_r, n_r, err_count_r;
    logic [IW-1:0]     idx_r, first_err_idx_r;
    logic [ADDR_W-1:0] base_r, mem_addr_r, addr_s;
    logic [DATA_W-1:0] mem_d_to_ram_r, rd_word_s;
    logic [1:0]        width_r;
    logic [15:0]       led_r;
    logic              rb_r, flush_pend_r, first_seen_r, wstrobe_r, rstrobe_r, done_r;
    logic              in_ready_s, push_s, start_s, last_s, mismatch_s, go_done_s, expire_s;

    mem_burst_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_buf (
        .clk_cpu (clk_cpu),
        .we      (push_s),
        .waddr   (count_r[IW-1:0]),
        .wdata   (in_data),
        .raddr   (idx_r),
        .rdata   (rd_word_s)
    );

    // Handshake, start condition, burst addressing and completion decode.
    always_comb begin
        in_ready_s = (state_r == ST_IDLE) && (count_r < CW'(DEPTH));
        push_s     = in_valid && in_ready_s;
        // A push takes priority so a same-cycle flush includes the pushed word.
        start_s    = (state_r == ST_IDLE) && !push_s &&
                     ((count_r == CW'(DEPTH)) || ((flush || flush_pend_r) && (count_r != {CW{1'b0}})));
        last_s     = ({1'b0, idx_r} == (n_r - CW'(1)));
        addr_s     = base_r + ADDR_W'(idx_r) * ADDR_W'(WORD_BYTES);
        mismatch_s = (mem_d_from_ram != rd_word_s);
        go_done_s  = (mem_transaction_complete && last_s &&
                      (((state_r == ST_WWAIT) && !rb_r) || (state_r == ST_RWAIT))) || expire_s;
    end

`ifdef MEM_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDW-1:0] wd_cnt_r;
    logic           timeout_r, in_wait_s, issue_s;

    // Watchdog expiry decode; a completing transaction always wins.
    always_comb begin
        in_wait_s = (state_r == ST_WWAIT) || (state_r == ST_RWAIT);
        issue_s   = ((state_r == ST_WRITE) || (state_r == ST_READ)) && mem_ready;
        expire_s  = in_wait_s && !mem_transaction_complete && (wd_cnt_r == WDW'(TIMEOUT_CYCLES - 1));
    end

    // Wait-cycle counter and sticky timeout flag.
    always_ff @(posedge clk_cpu) begin
        if (rst) begin
            wd_cnt_r  <= {WDW{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            if (issue_s) begin
                wd_cnt_r <= {WDW{1'b0}};
            end else if (in_wait_s) begin
                wd_cnt_r <= wd_cnt_r + WDW'(1);
            end else begin
                wd_cnt_r <= wd_cnt_r;
            end
            if (expire_s) begin
                timeout_r <= 1'b1;
            end else begin
                timeout_r <= timeout_r;
            end
        end
    end

    assign timeout = timeout_r;
`else
    assign expire_s = 1'b0;
    assign timeout  = 1'b0;
`endif

    // Burst control FSM and registered memory-side outputs.
    always_ff @(posedge clk_cpu) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            count_r         <= {CW{1'b0}};
            n_r             <= {CW{1'b0}};
            idx_r           <= {IW{1'b0}};
            err_count_r     <= {CW{1'b0}};
            first_err_idx_r <= {IW{1'b0}};
            first_seen_r    <= 1'b0;
            flush_pend_r    <= 1'b0;
            base_r          <= {ADDR_W{1'b0}};
            rb_r            <= 1'b0;
            mem_addr_r      <= {ADDR_W{1'b0}};
            mem_d_to_ram_r  <= {DATA_W{1'b0}};
            width_r         <= 2'd0;
            wstrobe_r       <= 1'b0;
            rstrobe_r       <= 1'b0;
            done_r          <= 1'b0;
            led_r           <= 16'h5555;
        end else begin
            wstrobe_r <= 1'b0;
            rstrobe_r <= 1'b0;
            done_r    <= go_done_s;
            case (state_r)
                ST_IDLE: begin
                    if (push_s) begin
                        count_r <= count_r + CW'(1);
                        if (flush) begin
                            flush_pend_r <= 1'b1;
                        end
                    end else if (start_s) begin
                        base_r          <= base_addr;
                        rb_r            <= readback_en;
                        n_r             <= count_r;
                        idx_r           <= {IW{1'b0}};
                        err_count_r     <= {CW{1'b0}};
                        first_err_idx_r <= {IW{1'b0}};
                        first_seen_r    <= 1'b0;
                        flush_pend_r    <= 1'b0;
                        state_r         <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (mem_ready) begin
                        mem_addr_r     <= addr_s;
                        mem_d_to_ram_r <= rd_word_s;
                        width_r        <= RAM_WIDTH64;
                        wstrobe_r      <= 1'b1;
                        state_r        <= ST_WWAIT;
                    end
                end
                ST_WWAIT: begin
                    if (mem_transaction_complete) begin
                        led_r <= rd_word_s[15:0];
                        if (!last_s) begin
                            idx_r   <= idx_r + IW'(1);
                            state_r <= ST_WRITE;
                        end else if (rb_r) begin
                            idx_r   <= {IW{1'b0}};
                            state_r <= ST_READ;
                        end else begin
                            state_r <= ST_DONE;
                        end
                    end else if (expire_s) begin
                        led_r   <= 16'hDEAD;
                        state_r <= ST_DONE;
                    end
                end
                ST_READ: begin
                    if (mem_ready) begin
                        mem_addr_r <= addr_s;
                        width_r    <= RAM_WIDTH64;
                        rstrobe_r  <= 1'b1;
                        state_r    <= ST_RWAIT;
                    end
                end
                ST_RWAIT: begin
                    if (mem_transaction_complete) begin
                        led_r <= mem_d_from_ram[DATA_W-1 -: 16];
                        if (mismatch_s) begin
                            err_count_r <= err_count_r + CW'(1);
                            if (!first_seen_r) begin
                                first_err_idx_r <= idx_r;
                                first_seen_r    <= 1'b1;
                            end
                        end
                        if (last_s) begin
                            state_r <= ST_DONE;
                        end else begin
                            idx_r   <= idx_r + IW'(1);
                            state_r <= ST_READ;
                        end
                    end else if (expire_s) begin
                        led_r   <= 16'hDEAD;
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    count_r <= {CW{1'b0}};
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready              = in_ready_s;
    assign busy                  = (state_r != ST_IDLE);
    assign done                  = done_r;
    assign mem_addr              = mem_addr_r;
    assign mem_d_to_ram          = mem_d_to_ram_r;
    assign mem_transaction_width = width_r;
    assign mem_wstrobe           = wstrobe_r;
    assign mem_rstrobe           = rstrobe_r;
    assign err_count             = err_count_r;
    assign first_err_idx         = first_err_idx_r;
    assign led                   = led_r;

endmodule

// File: tb/tb_mem_burst_tester.sv
// Randomized bench for mem_burst_tester with a behavioural RAM and burst reference model.
module tb_mem_burst_tester;
    import mem_burst_pkg::*;

    localparam int DEPTH = 8;
    localparam int TMO   = 16;

    logic        clk_cpu = 1'b0;
    logic        rst = 1'b1, in_valid = 1'b0, flush = 1'b0, readback_en = 1'b0, mem_ready = 1'b1;
    logic [63:0] in_data = 64'd0;
    logic [27:0] base_addr = 28'd0;
    logic        mem_transaction_complete;
    logic [63:0] mem_d_from_ram;
    logic        in_ready, mem_wstrobe, mem_rstrobe, busy, done, timeout;
    logic [27:0] mem_addr;
    logic [63:0] mem_d_to_ram;
    logic [1:0]  mem_transaction_width;
    logic [3:0]  err_count;
    logic [2:0]  first_err_idx;
    logic [15:0] led;

    mem_burst_tester #(.DATA_W(64), .ADDR_W(28), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_cpu(clk_cpu), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .flush(flush), .readback_en(readback_en), .base_addr(base_addr), .mem_ready(mem_ready),
        .mem_transaction_complete(mem_transaction_complete), .mem_d_from_ram(mem_d_from_ram),
        .mem_addr(mem_addr), .mem_d_to_ram(mem_d_to_ram), .mem_transaction_width(mem_transaction_width),
        .mem_wstrobe(mem_wstrobe), .mem_rstrobe(mem_rstrobe), .busy(busy), .done(done),
        .err_count(err_count), .first_err_idx(first_err_idx), .timeout(timeout), .led(led)
    );

    always #5 clk_cpu = ~clk_cpu;

    int          tests_run = 0, tests_failed = 0;
    logic [63:0] stim_q[$];
    logic [27:0] wr_addr_q[$], rd_addr_q[$];
    logic [63:0] wr_data_q[$];
    logic [63:0] ram [logic [27:0]];
    bit          corrupt_mask [DEPTH];
    bit          resp_en = 1'b1;
    int          pend = 0, done_cnt = 0, bad_strobe = 0, bad_width = 0;
    logic [63:0] pend_data, rd_val;
    logic        ready_at_edge = 1'b1;

    function automatic logic [27:0] exp_addr(input logic [27:0] base, input int k);
        return base + 28'(k * 8);
    endfunction

    always @(posedge clk_cpu) ready_at_edge <= mem_ready;

    // RAM model: records transactions, answers after 1..3 cycles, optionally corrupts reads.
    always @(negedge clk_cpu) begin
        mem_transaction_complete = 1'b0;
        if ((mem_wstrobe || mem_rstrobe) && !ready_at_edge) bad_strobe++;
        if (done) done_cnt++;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                mem_transaction_complete = 1'b1;
                mem_d_from_ram = pend_data;
            end
        end
        if (mem_wstrobe) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_d_to_ram);
            ram[mem_addr] = mem_d_to_ram;
            if (mem_transaction_width !== RAM_WIDTH64) bad_width++;
            pend_data = 64'd0;
            if (resp_en) pend = $urandom_range(3, 1);
        end
        if (mem_rstrobe) begin
            rd_val = ram.exists(mem_addr) ? ram[mem_addr] : 64'd0;
            if (rd_addr_q.size() < DEPTH && corrupt_mask[rd_addr_q.size()])
                rd_val = rd_val ^ (64'd1 << $urandom_range(63, 0));
            rd_addr_q.push_back(mem_addr);
            if (mem_transaction_width !== RAM_WIDTH64) bad_width++;
            pend_data = rd_val;
            if (resp_en) pend = $urandom_range(3, 1);
        end
    end

    task automatic clear_logs();
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
        foreach (corrupt_mask[i]) corrupt_mask[i] = 1'b0;
    endtask

    task automatic fill_random(input int n);
        stim_q.delete();
        for (int i = 0; i < n; i++) stim_q.push_back({$urandom, $urandom});
    endtask

    // mode 0: fill to DEPTH, 1: flush with the last push, 2: flush one cycle after the pushes
    task automatic push_words(input int mode);
        for (int i = 0; i < stim_q.size(); i++) begin
            int t = 0;
            while (!in_ready && t < 100) begin @(posedge clk_cpu); #1; t++; end
            tests_run++;
            if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL push_ready: in_ready=%b required 1", in_ready); end
            in_valid = 1'b1; in_data = stim_q[i];
            flush = (mode == 1) && (i == stim_q.size() - 1);
            @(posedge clk_cpu); #1;
            in_valid = 1'b0; flush = 1'b0;
        end
        if (mode == 2) begin flush = 1'b1; @(posedge clk_cpu); #1; flush = 1'b0; end
    endtask

    task automatic wait_done(input string name);
        int d0 = done_cnt;
        bit seen = 1'b0;
        for (int c = 0; c < 4000 && !seen; c++) begin @(negedge clk_cpu); #1; if (done_cnt > d0) seen = 1'b1; end
        tests_run++;
        if (!seen) begin tests_failed++; $display("FAIL %s_done_wait: no done pulse within bound", name); end
        repeat (4) @(negedge clk_cpu);
        #1;
        tests_run++;
        if (done_cnt !== d0 + 1) begin tests_failed++; $display("FAIL %s_done_once: pulses=%0d required 1", name, done_cnt - d0); end
    endtask

    task automatic test_reset();
        rst = 1'b1; repeat (3) @(posedge clk_cpu); #1;
        tests_run++;
        if ({busy, done, mem_wstrobe, mem_rstrobe, timeout, in_ready} !== 6'b000001) begin
            tests_failed++; $display("FAIL reset_flags: busy/done/ws/rs/to/rdy=%b required 000001",
                                     {busy, done, mem_wstrobe, mem_rstrobe, timeout, in_ready});
        end
        tests_run++;
        if (led !== 16'h5555) begin tests_failed++; $display("FAIL reset_led: got %h required 5555", led); end
        tests_run++;
        if ({mem_addr, mem_d_to_ram, mem_transaction_width, err_count, first_err_idx} !== 101'd0) begin
            tests_failed++; $display("FAIL reset_regs: addr=%h data=%h w=%0d err=%0d fidx=%0d required all 0",
                                     mem_addr, mem_d_to_ram, mem_transaction_width, err_count, first_err_idx);
        end
        rst = 1'b0; @(posedge clk_cpu); #1;
    endtask

    task automatic test_full_burst();
        clear_logs(); stim_q.delete();
        for (int k = 1; k <= 8; k++) stim_q.push_back({8{8'(k)}});
        base_addr = 28'h1010100; readback_en = 1'b1;
        push_words(0); wait_done("full");
        tests_run++;
        if (wr_addr_q.size() != 8 || rd_addr_q.size() != 8) begin
            tests_failed++; $display("FAIL full_counts: writes=%0d reads=%0d required 8/8", wr_addr_q.size(), rd_addr_q.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                tests_run++;
                if (wr_addr_q[k] !== exp_addr(28'h1010100, k) || wr_data_q[k] !== stim_q[k] || rd_addr_q[k] !== exp_addr(28'h1010100, k)) begin
                    tests_failed++; $display("FAIL full_word%0d: waddr=%h wdata=%h raddr=%h required %h/%h",
                                             k, wr_addr_q[k], wr_data_q[k], rd_addr_q[k], exp_addr(28'h1010100, k), stim_q[k]);
                end
            end
        end
        tests_run++;
        if (err_count !== 4'd0) begin tests_failed++; $display("FAIL full_err: got %0d required 0", err_count); end
        tests_run++;
        if (led !== 16'h0808) begin tests_failed++; $display("FAIL full_led: got %h required 0808", led); end
        tests_run++;
        if (bad_width != 0) begin tests_failed++; $display("FAIL full_width: %0d strobes with width!=3", bad_width); end
    endtask

    task automatic test_flush_write_only();
        logic [27:0] b;
        clear_logs(); fill_random(3);
        b = 28'($urandom); base_addr = b; readback_en = 1'b0;
        push_words(2); wait_done("flush");
        tests_run++;
        if (wr_addr_q.size() != 3 || rd_addr_q.size() != 0) begin
            tests_failed++; $display("FAIL flush_counts: writes=%0d reads=%0d required 3/0", wr_addr_q.size(), rd_addr_q.size());
        end else begin
            tests_run++;
            if (wr_addr_q[2] !== exp_addr(b, 2) || wr_data_q[1] !== stim_q[1]) begin
                tests_failed++; $display("FAIL flush_xfer: addr2=%h data1=%h required %h/%h", wr_addr_q[2], wr_data_q[1], exp_addr(b, 2), stim_q[1]);
            end
        end
        tests_run++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL flush_idle: in_ready=%b busy=%b required 1/0", in_ready, busy); end
        tests_run++;
        if (led !== stim_q[2][15:0]) begin tests_failed++; $display("FAIL flush_led: got %h required %h", led, stim_q[2][15:0]); end
    endtask

    task automatic test_corrupt();
        clear_logs(); fill_random(8); corrupt_mask[5] = 1'b1;
        base_addr = 28'($urandom); readback_en = 1'b1;
        push_words(0); wait_done("corrupt");
        tests_run++;
        if (err_count !== 4'd1 || first_err_idx !== 3'd5) begin
            tests_failed++; $display("FAIL corrupt_err: err=%0d first=%0d required 1/5", err_count, first_err_idx);
        end
        tests_run++;
        if (led !== stim_q[7][63:48]) begin tests_failed++; $display("FAIL corrupt_led: got %h required %h", led, stim_q[7][63:48]); end
    endtask

    task automatic test_wrap();
        clear_logs(); fill_random(8);
        base_addr = 28'hFFFFFF8; readback_en = 1'b0;
        push_words(0); wait_done("wrap");
        tests_run++;
        if (wr_addr_q.size() != 8) begin
            tests_failed++; $display("FAIL wrap_count: writes=%0d required 8", wr_addr_q.size());
        end else begin
            tests_run++;
            if (wr_addr_q[0] !== 28'hFFFFFF8 || wr_addr_q[1] !== 28'h0000000 || wr_addr_q[7] !== 28'h0000030) begin
                tests_failed++; $display("FAIL wrap_addr: a0=%h a1=%h a7=%h required FFFFFF8/0000000/0000030",
                                         wr_addr_q[0], wr_addr_q[1], wr_addr_q[7]);
            end
        end
    endtask

    task automatic test_ready_stall();
        clear_logs(); fill_random(8);
        base_addr = 28'($urandom); readback_en = 1'b1; mem_ready = 1'b0; bad_strobe = 0;
        push_words(0);
        repeat (20) @(negedge clk_cpu);
        #1;
        tests_run++;
        if (wr_addr_q.size() != 0 || busy !== 1'b1) begin
            tests_failed++; $display("FAIL stall_nostrobe: writes=%0d busy=%b required 0/1", wr_addr_q.size(), busy);
        end
        mem_ready = 1'b1;
        wait_done("stall");
        tests_run++;
        if (wr_addr_q.size() != 8 || rd_addr_q.size() != 8 || err_count !== 4'd0) begin
            tests_failed++; $display("FAIL stall_after: writes=%0d reads=%0d err=%0d required 8/8/0", wr_addr_q.size(), rd_addr_q.size(), err_count);
        end
        tests_run++;
        if (bad_strobe != 0) begin tests_failed++; $display("FAIL stall_ready_rule: %0d strobes while not ready", bad_strobe); end
    endtask

    task automatic test_push_flush_same_cycle();
        clear_logs(); fill_random(1);
        base_addr = 28'($urandom); readback_en = 1'b1;
        push_words(1); wait_done("pushflush");
        tests_run++;
        if (wr_addr_q.size() != 1 || rd_addr_q.size() != 1 || err_count !== 4'd0) begin
            tests_failed++; $display("FAIL pushflush: writes=%0d reads=%0d err=%0d required 1/1/0", wr_addr_q.size(), rd_addr_q.size(), err_count);
        end
    endtask

    task automatic test_rst_mid_burst();
        int d0;
        bit reached = 1'b0;
        clear_logs(); fill_random(8);
        base_addr = 28'($urandom); readback_en = 1'b1;
        push_words(0);
        for (int c = 0; c < 500 && !reached; c++) begin @(negedge clk_cpu); #1; if (rd_addr_q.size() >= 3) reached = 1'b1; end
        tests_run++;
        if (!reached) begin tests_failed++; $display("FAIL rstmid_reach: reads=%0d required 3", rd_addr_q.size()); end
        d0 = done_cnt;
        rst = 1'b1; @(posedge clk_cpu); #1;
        tests_run++;
        if ({busy, mem_wstrobe, mem_rstrobe} !== 3'b000 || led !== 16'h5555 || in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL rstmid_state: busy/ws/rs=%b led=%h in_ready=%b required 000/5555/1",
                                     {busy, mem_wstrobe, mem_rstrobe}, led, in_ready);
        end
        rst = 1'b0;
        repeat (12) @(negedge clk_cpu);
        #1;
        tests_run++;
        if (done_cnt != d0 || busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_nodone: pulses=%0d busy=%b required 0/0", done_cnt - d0, busy); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int n, mode, exp_err, exp_first;
            bit rb;
            logic [27:0] b;
            clear_logs();
            n = $urandom_range(DEPTH, 1);
            mode = (n == DEPTH) ? $urandom_range(2, 0) : $urandom_range(2, 1);
            rb = 1'($urandom_range(1, 0));
            b = 28'($urandom);
            fill_random(n);
            exp_err = 0; exp_first = -1;
            for (int k = 0; k < DEPTH; k++) begin
                corrupt_mask[k] = ($urandom_range(3, 0) == 0);
                if (rb && k < n && corrupt_mask[k]) begin exp_err++; if (exp_first < 0) exp_first = k; end
            end
            base_addr = b; readback_en = rb;
            push_words(mode); wait_done("rand");
            tests_run++;
            if (wr_addr_q.size() != n || rd_addr_q.size() != (rb ? n : 0)) begin
                tests_failed++; $display("FAIL rand%0d_counts: writes=%0d reads=%0d required %0d/%0d", it, wr_addr_q.size(), rd_addr_q.size(), n, rb ? n : 0);
            end else begin
                for (int k = 0; k < n; k++) begin
                    tests_run++;
                    if (wr_addr_q[k] !== exp_addr(b, k) || wr_data_q[k] !== stim_q[k]) begin
                        tests_failed++; $display("FAIL rand%0d_w%0d: addr=%h data=%h required %h/%h", it, k, wr_addr_q[k], wr_data_q[k], exp_addr(b, k), stim_q[k]);
                    end
                end
            end
            tests_run++;
            if (err_count !== 4'(exp_err) || (exp_err > 0 && first_err_idx !== 3'(exp_first))) begin
                tests_failed++; $display("FAIL rand%0d_err: err=%0d first=%0d required %0d/%0d", it, err_count, first_err_idx, exp_err, exp_first);
            end
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        int d0, cyc;
        bit seen = 1'b0;
        clear_logs(); fill_random(1);
        resp_en = 1'b0; base_addr = 28'($urandom); readback_en = 1'b0;
        push_words(1);
        for (int c = 0; c < 100 && wr_addr_q.size() == 0; c++) begin @(negedge clk_cpu); #1; end
        d0 = done_cnt; cyc = 0;
        for (int c = 0; c < 200 && !seen; c++) begin @(negedge clk_cpu); #1; cyc++; if (done_cnt > d0) seen = 1'b1; end
        tests_run++;
        if (!seen || cyc != TMO) begin tests_failed++; $display("FAIL timeout_latency: seen=%b cycles=%0d required 1/%0d", seen, cyc, TMO); end
        tests_run++;
        if (timeout !== 1'b1 || led !== 16'hDEAD) begin tests_failed++; $display("FAIL timeout_flag: timeout=%b led=%h required 1/DEAD", timeout, led); end
        repeat (5) @(negedge clk_cpu);
        #1;
        tests_run++;
        if (timeout !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL timeout_sticky: timeout=%b busy=%b required 1/0", timeout, busy); end
        resp_en = 1'b1;
        rst = 1'b1; @(posedge clk_cpu); #1; rst = 1'b0;
        tests_run++;
        if (timeout !== 1'b0) begin tests_failed++; $display("FAIL timeout_clear: got %b required 0", timeout); end
    endtask
`endif

    initial begin
        #3000000;
        $display("FAIL global_watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_burst();
        test_flush_write_only();
        test_push_flush_same_cycle();
        test_corrupt();
        test_wrap();
        test_ready_stall();
        test_rst_mid_burst();
        test_random();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`else
        tests_run++;
        if (timeout !== 1'b0) begin tests_failed++; $display("FAIL timeout_off: got %b required 0", timeout); end
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_burst_tester.md
Name: mem_burst_tester

Overview:
- Parametrised successor to the single-word RAM write/readback traffic generator.
- Buffers up to DEPTH words pushed from the CPU side, then writes them as a burst to consecutive 64-bit RAM addresses through the mem_example CPU-side port.
- Optionally reads the words back and compares them, counting mismatches.
- Sits between the CPU/LRU datapath and mem_example, in the clk_cpu domain; drives a 16-bit LED status word.

Parameters:
- DATA_W, 64, word width; must be 64 (mem_example data bus), kept for future widths
- ADDR_W, 28, mem_example byte address width
- DEPTH, 8, buffer depth in words; power of 2, 2..64
- TIMEOUT_CYCLES, 4096, watchdog limit (only used with MEM_TIMEOUT_EN)

Ports:
- clk_cpu  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  push request
- in_data  in  DATA_W  word to buffer
- in_ready  out  1  buffer can accept
- flush  in  1  start a burst with the words currently buffered
- readback_en  in  1  1 = write then read/compare; 0 = write only
- base_addr  in  ADDR_W  burst start byte address
- mem_ready  in  1  mem_example ready
- mem_transaction_complete  in  1  mem_example done pulse
- mem_d_from_ram  in  DATA_W  read data
- mem_addr  out  ADDR_W  transaction address
- mem_d_to_ram  out  DATA_W  write data
- mem_transaction_width  out  2  width code
- mem_wstrobe  out  1  one-cycle write strobe
- mem_rstrobe  out  1  one-cycle read strobe
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst end
- err_count  out  $clog2(DEPTH)+1  mismatches in the last burst
- first_err_idx  out  $clog2(DEPTH)  index of the first mismatch
- timeout  out  1  sticky watchdog flag (0 when feature off)
- led  out  16  status display

Behaviour:
- Reset values:
  - All strobes, busy, done, timeout, err_count, first_err_idx, count and idx = 0.
  - State = IDLE; mem_addr = 0; mem_d_to_ram = 0; width = 0; led = 16'h5555.
  - Buffer contents are don't-care.
- States: IDLE, WRITE, WWAIT, READ, RWAIT, DONE.
- IDLE:
  - in_ready = (count < DEPTH).
  - in_valid & in_ready writes buf[count] and increments count.
  - Start condition: count == DEPTH, or flush with count > 0. A push and a flush in the same cycle count the pushed word, and the burst starts next cycle.
  - On start, sample base_addr and readback_en; set n = count, idx = 0, err_count = 0; go to WRITE.
  - Flush with count == 0 is ignored.
- Every state other than IDLE: in_ready = 0, busy = 1.
- WRITE, when mem_ready:
  - mem_addr = base + idx*8, modulo 2^ADDR_W (wrap allowed).
  - mem_d_to_ram = buf[idx]; width = RAM_WIDTH64; assert mem_wstrobe for exactly one cycle.
  - Go to WWAIT.
- WWAIT: on mem_transaction_complete, led = buf[idx][15:0]. Then:
  - idx == n-1: go to READ with idx = 0 if the sampled readback_en is 1, otherwise go to DONE.
  - otherwise idx++ and return to WRITE.
- READ: same as WRITE, but asserts mem_rstrobe, width = RAM_WIDTH64, and does not drive data.
- RWAIT: on complete:
  - Compare mem_d_from_ram to buf[idx]. On mismatch, err_count++; if it is the first mismatch, first_err_idx = idx.
  - led = mem_d_from_ram[63:48].
  - Advance idx as in WWAIT, going to DONE after n-1.
- DONE: done = 1 for one cycle, count = 0, go to IDLE. err_count and first_err_idx hold until the next start.
- A complete pulse arriving outside WWAIT/RWAIT is ignored.
- A strobe is never issued while mem_ready = 0.
- Synchronous rst mid-burst: the state returns to IDLE on the next edge and strobes drop in that edge. The buffer is discarded, and no done pulse is produced.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on every strobe and counts while in WWAIT/RWAIT.
  - When it reaches TIMEOUT_CYCLES: set timeout (sticky until rst), drive led = 16'hDEAD, and go to DONE (done pulses), abandoning the remaining words.
- Undefined: no counter; timeout is tied to 0; WWAIT/RWAIT wait indefinitely.

Decomposition:
- Package mem_burst_pkg holds:
  - width codes RAM_WIDTH8=2'd0, RAM_WIDTH16=2'd1, RAM_WIDTH32=2'd2, RAM_WIDTH64=2'd3;
  - the state enum;
  - WORD_BYTES = 8.
- Sub-module mem_burst_buf: the DEPTH x DATA_W storage with write port (push) and async read port (idx). It contains no control logic.

Test Plan:
- Push 8 words 64'h0101..01 through 64'h0808..08 with base 28'h1010100 and readback_en = 1, using a perfect memory model:
  - 8 writes at 28'h1010100 + 8k, then 8 reads;
  - err_count = 0; done pulses once; led = 16'h0808.
- Push 3 words and then flush, with readback_en = 0:
  - exactly 3 wstrobes, no rstrobe;
  - done pulses; count returns to 0; in_ready = 1.
- Memory model corrupts word 5 on read:
  - err_count = 1, first_err_idx = 5.
- base_addr = 28'hFFFFFF8, DEPTH = 8:
  - second address wraps to 28'h0000000.
- Hold mem_ready = 0 for 20 cycles in WRITE:
  - no strobe is issued until ready rises.
- Assert rst during RWAIT of word 2:
  - next cycle: busy = 0, strobes = 0, led = 16'h5555, no done pulse.
- With MEM_TIMEOUT_EN defined, TIMEOUT_CYCLES = 16, and complete never arriving:
  - timeout = 1 after 16 cycles in WWAIT; led = 16'hDEAD; done pulses.
